// File: rtl/regfile_wb_ctrl_if.sv
// Writeback-controller bus: ALU result, load issue/return, hazard query and
// the register-file write port (WE3/A3/WD3).
interface regfile_wb_ctrl_if #(
    parameter int unsigned data_width = 32,
    parameter int unsigned adr_width  = 5,
    parameter int unsigned LQ_DEPTH   = 4
);
    localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

    logic                  alu_valid;
    logic [adr_width-1:0]  alu_rd;
    logic [data_width-1:0] alu_data;

    logic                  issue_ld;
    logic [adr_width-1:0]  issue_rd;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [adr_width-1:0]  ld_rd;
    logic [data_width-1:0] ld_data;

    logic [adr_width-1:0]  rs1;
    logic [adr_width-1:0]  rs2;
    logic                  stall;

    logic                  WE3;
    logic [adr_width-1:0]  A3;
    logic [data_width-1:0] WD3;
    logic [CNT_W-1:0]      lq_count;

    // Execute/memory/decode side: drives requests, observes status and writes
    modport master (
        output alu_valid, alu_rd, alu_data,
        output issue_ld, issue_rd,
        output ld_valid, ld_rd, ld_data,
        output rs1, rs2,
        input  ld_ready, stall,
        input  WE3, A3, WD3, lq_count
    );

    // Writeback controller side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  issue_ld, issue_rd,
        input  ld_valid, ld_rd, ld_data,
        input  rs1, rs2,
        output ld_ready, stall,
        output WE3, A3, WD3, lq_count
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: merges ALU results and queued load
// returns onto the single write port and tracks pending loads per register.
// Optional feature macro: WB_BYPASS_EN (load return with empty queue and no
// ALU write goes straight to the write port, skipping the queue).
module regfile_wb_ctrl #(
    parameter int unsigned data_width = 32,
    parameter int unsigned adr_width  = 5,
    parameter int unsigned LQ_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wb_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 1 << adr_width;

    // Load queue storage and bookkeeping
    logic [adr_width-1:0]  lq_rd_q   [LQ_DEPTH];
    logic [data_width-1:0] lq_data_q [LQ_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    // Registered write port
    logic                  we_q,       we_d;
    logic [adr_width-1:0]  a_q,        a_d;
    logic [data_width-1:0] wd_q,       wd_d;
    logic                  src_load_q, src_load_d;

    // Pending-load scoreboard
    logic [NREG-1:0]       pend_q, pend_d;

    logic full_c;
    logic empty_c;
    logic bypass_c;
    logic push_c;
    logic pop_c;

    assign full_c  = (count_q == CNT_W'(LQ_DEPTH));
    assign empty_c = (count_q == '0);

`ifdef WB_BYPASS_EN
    // Idle write port and empty queue: the returning load takes the port directly
    assign bypass_c = bus.ld_valid && empty_c && !bus.alu_valid;
`else
    assign bypass_c = 1'b0;
`endif

    // Ready depends only on registered occupancy, so a full queue never accepts
    assign push_c = bus.ld_valid && !full_c && !bypass_c;
    assign pop_c  = !bus.alu_valid && !empty_c;

    // Queue pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Write arbitration: ALU first, then queue head, then bypassed load
    always_comb begin
        we_d       = 1'b0;
        a_d        = a_q;
        wd_d       = wd_q;
        src_load_d = 1'b0;
        if (bus.alu_valid) begin
            if (bus.alu_rd != '0) begin
                we_d = 1'b1;
                a_d  = bus.alu_rd;
                wd_d = bus.alu_data;
            end
        end else if (pop_c) begin
            if (lq_rd_q[rd_ptr_q] != '0) begin
                we_d       = 1'b1;
                a_d        = lq_rd_q[rd_ptr_q];
                wd_d       = lq_data_q[rd_ptr_q];
                src_load_d = 1'b1;
            end
        end else if (bypass_c) begin
            if (bus.ld_rd != '0) begin
                we_d       = 1'b1;
                a_d        = bus.ld_rd;
                wd_d       = bus.ld_data;
                src_load_d = 1'b1;
            end
        end
    end

    // Scoreboard: clear on the commit edge of a load write, set on issue (set wins)
    always_comb begin
        pend_d = pend_q;
        if (we_q && src_load_q) begin
            pend_d[a_q] = 1'b0;
        end
        if (bus.issue_ld && (bus.issue_rd != '0)) begin
            pend_d[bus.issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            a_q        <= '0;
            wd_q       <= '0;
            src_load_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            a_q        <= a_d;
            wd_q       <= wd_d;
            src_load_q <= src_load_d;
            pend_q     <= pend_d;
        end
    end

    // Queue payload storage; contents are only meaningful under count_q
    always_ff @(posedge clk) begin
        if (push_c) begin
            lq_rd_q[wr_ptr_q]   <= bus.ld_rd;
            lq_data_q[wr_ptr_q] <= bus.ld_data;
        end
    end

    assign bus.ld_ready = !full_c;
    assign bus.stall    = pend_q[bus.rs1] | pend_q[bus.rs2] | full_c;
    assign bus.WE3      = we_q;
    assign bus.A3       = a_q;
    assign bus.WD3      = wd_q;
    assign bus.lq_count = count_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: behavioural queue/scoreboard model feeding an
// expected-write queue, with an independent monitor on the write port.
module tb_regfile_wb_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned D  = 4;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic clk;
    logic rst_n;

    regfile_wb_ctrl_if #(.data_width(DW), .adr_width(AW), .LQ_DEPTH(D)) bus ();

    regfile_wb_ctrl #(.data_width(DW), .adr_width(AW), .LQ_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    ent_t          mq[$];     // model load queue
    ent_t          exp_q[$];  // expected register-file writes, in order
    logic [31:0]   pend;      // model pending bits
    int            last_clr;  // register committed by a load at the previous edge

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        pend     = '0;
        last_clr = -1;
    endtask

    // One cycle: drive inputs, check status against the model, predict the edge
    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic iv, input logic [AW-1:0] ird,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bit   full;
        bit   do_push;
        bit   wr;
        bit   wr_load;
        ent_t w;
        @(negedge clk);
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
        bus.issue_ld  = iv;  bus.issue_rd = ird;
        bus.ld_valid  = lv;  bus.ld_rd = lrd;   bus.ld_data = ldd;
        bus.rs1 = r1;        bus.rs2 = r2;
        #1;
        full = (mq.size() == D);
        chk("stall",    64'(bus.stall),    64'(pend[r1] | pend[r2] | full));
        chk("ld_ready", 64'(bus.ld_ready), 64'(!full));
        chk("lq_count", 64'(bus.lq_count), 64'(mq.size()));

        do_push = lv && !full;
        wr      = 1'b0;
        wr_load = 1'b0;
        w.rd    = '0;
        w.data  = '0;
        if (av) begin
            wr = 1'b1; w.rd = ard; w.data = ad;
        end else if (mq.size() != 0) begin
            w = mq.pop_front(); wr = 1'b1; wr_load = 1'b1;
        end else if (BYP && lv) begin
            w.rd = lrd; w.data = ldd; wr = 1'b1; wr_load = 1'b1; do_push = 1'b0;
        end
        if (do_push) begin
            ent_t e;
            e.rd = lrd; e.data = ldd;
            mq.push_back(e);
        end
        if (last_clr > 0) pend[last_clr] = 1'b0;
        if (iv && ird != 0) pend[ird] = 1'b1;
        last_clr = (wr && wr_load && w.rd != 0) ? int'(w.rd) : -1;
        if (wr && w.rd != 0) exp_q.push_back(w);
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, r1, r2);
    endtask

    task automatic rand_cycle();
        drive(($urandom_range(0, 2) == 0), AW'($urandom), $urandom,
              ($urandom_range(0, 3) == 0), AW'($urandom),
              ($urandom_range(0, 1) == 0), AW'($urandom), $urandom,
              AW'($urandom), AW'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (mq.size() != 0 || exp_q.size() != 0); i++) idle('0, '0);
        idle('0, '0);
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        chk("drain_count", 64'(bus.lq_count), 64'd0);
    endtask

    // Monitor: every write on the port must match the next expected write
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.WE3 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_we3", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_addr", 64'(bus.A3),  64'(e.rd));
                    chk("wb_data", 64'(bus.WD3), 64'(e.data));
                end
            end
        end
    end

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.issue_ld  = 1'b0; bus.issue_rd = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd = '0;  bus.ld_data = '0;
        bus.rs1 = '0; bus.rs2 = '0;
        model_clear();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we3",   64'(bus.WE3),      64'd0);
        chk("rst_a3",    64'(bus.A3),       64'd0);
        chk("rst_wd3",   64'(bus.WD3),      64'd0);
        chk("rst_count", 64'(bus.lq_count), 64'd0);
        chk("rst_ready", 64'(bus.ld_ready), 64'd1);
        chk("rst_stall", 64'(bus.stall),    64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ALU write, one-cycle latency, then idle
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        @(posedge clk); #1;
        chk("alu_we3", 64'(bus.WE3), 64'd1);
        chk("alu_a3",  64'(bus.A3),  64'd5);
        chk("alu_wd3", 64'(bus.WD3), 64'hDEADBEEF);
        idle('0, '0);
        @(posedge clk); #1;
        chk("alu_we3_drop", 64'(bus.WE3), 64'd0);

        // ALU write to r0 is suppressed
        drive(1'b1, 5'd0, 32'h1234, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        @(posedge clk); #1;
        chk("r0_we3", 64'(bus.WE3), 64'd0);

        // Load-use hazard on r7 and its release after commit
        drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0, '0, '0, '0);
        idle(5'd7, '0);
        chk("ld7_stall_pending", 64'(bus.stall), 64'd1);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, '0);
        for (int i = 0; i < (BYP ? 1 : 2); i++) begin
            idle(5'd7, '0);
            chk("ld7_stall_hold", 64'(bus.stall), 64'd1);
        end
        idle(5'd7, '0);
        chk("ld7_stall_drop", 64'(bus.stall), 64'd0);

        // Re-issue to r3 on the commit edge of the previous r3 load: set wins
        drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0, '0, '0, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd3, 32'h33333333, '0, 5'd3);
        if (!BYP) idle('0, 5'd3);
        drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0, '0, '0, 5'd3);
        idle('0, 5'd3);
        chk("r3_set_wins", 64'(bus.stall), 64'd1);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd3, 32'h44444444, '0, '0);
        drain();

        // ALU busy for 6 cycles while 4 loads return: queue fills, then drains in order
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, AW'(20 + i), 32'hC000_0000 + 32'(i), 1'b0, '0,
                  (i < 4), AW'(10 + i), 32'hB000_0000 + 32'(i), '0, '0);
            if (i >= 4) begin
                chk("full_count", 64'(bus.lq_count), 64'd4);
                chk("full_ready", 64'(bus.ld_ready), 64'd0);
                chk("full_stall", 64'(bus.stall),    64'd1);
            end
        end
        drain();

        // Randomized traffic
        for (int i = 0; i < 300; i++) rand_cycle();

        // Asynchronous reset with loads queued behind ALU traffic
        drain();
        for (int i = 0; i < 3; i++)
            drive(1'b1, AW'(1 + i), 32'hE0 + 32'(i), 1'b1, AW'(15 + i),
                  1'b1, AW'(15 + i), 32'hF0 + 32'(i), '0, '0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_we3",   64'(bus.WE3),      64'd0);
        chk("async_rst_count", 64'(bus.lq_count), 64'd0);
        model_clear();
        bus.alu_valid = 1'b0; bus.issue_ld = 1'b0; bus.ld_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) idle(5'd15, 5'd16);

        for (int i = 0; i < 100; i++) rand_cycle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
